// File: rtl/esp_spi_pkg.sv
// esp_spi_pkg: shared constants, FSM state type and CRC-8 helper for the ESP32 SPI target.
// Optional feature macro: ESP_SPI_CRC_EN (appends a CRC-8 byte after every data word).
package esp_spi_pkg;

    localparam logic [7:0]  CMD_READ   = 8'hA5;
    localparam logic [23:0] EMPTY_WORD = 24'h800000;
    localparam logic [7:0]  CRC8_POLY  = 8'h07;
    localparam int unsigned SAMPLE_W   = 24;
    localparam int unsigned HDR_BITS   = 8;
    localparam int unsigned CNT_W      = 5;
`ifdef ESP_SPI_CRC_EN
    localparam int unsigned WORD_BITS  = 32;
`else
    localparam int unsigned WORD_BITS  = 24;
`endif

    typedef enum logic [2:0] {
        WAIT_CS_HIGH = 3'd0,
        IDLE         = 3'd1,
        HDR          = 3'd2,
        DATA         = 3'd3,
        DRAIN        = 3'd4
    } esp_spi_state_t;

    // CRC-8, init 0x00, MSB first over the three sample bytes
    function automatic logic [7:0] crc8(input logic [23:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 23; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
        end
        return c;
    endfunction

endpackage

// File: rtl/esp_sample_fifo.sv
// esp_sample_fifo: synchronous sample FIFO; pointers carry an extra MSB to tell full from empty.
module esp_sample_fifo #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Status and accept decisions; a pop frees the slot a same-cycle push needs when full
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        dout    = mem[rd_ptr[AW-1:0]];
    end

    // Storage write port
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointers and occupancy count
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/esp_spi_target.sv
// esp_spi_target: SPI mode-0 target streaming buffered ECG samples to the ESP32.
// Optional feature macro: ESP_SPI_CRC_EN (CRC-8 byte after each data word).
module esp_spi_target
    import esp_spi_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 64,
    parameter int unsigned DATA_W      = 24,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             sample_in,
    input  logic                          sample_valid,
    input  logic                          spi_sck,
    input  logic                          spi_cs,
    input  logic                          spi_mosi,
    output logic                          spi_miso,
    output logic                          spi_miso_oe,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          busy
);

    localparam int unsigned WORD_W = DATA_W + WORD_BITS - SAMPLE_W;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_s, cs_s, mosi_s, sck_d, cs_d;
    logic                   sck_rise, sck_fall, cs_rise, cs_fall;

    esp_spi_state_t         state, state_nxt;
    logic [WORD_W-1:0]      tx_sr, tx_sr_nxt;
    logic [CNT_W-1:0]       bit_cnt, bit_cnt_nxt, last_idx;
    logic                   word_done, word_done_nxt;
    logic [7:0]             cmd, cmd_nxt;
    logic                   miso_nxt, oe_nxt, ovf_nxt;

    logic                   pop_c, fifo_full, fifo_empty;
    logic [DATA_W-1:0]      fifo_dout, sample_word;
    logic [WORD_W-1:0]      data_word, hdr_word;
    logic [6:0]             level_sat;

    esp_sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (sample_valid),
        .pop   (pop_c),
        .din   (sample_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Oversampling synchronizers plus one delay stage for edge detection; CS resets low
    // so a select held across reset is never mistaken for a fresh falling edge
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sck_sync  <= SYNC_STAGES'({sck_sync, spi_sck});
            cs_sync   <= SYNC_STAGES'({cs_sync, spi_cs});
            mosi_sync <= SYNC_STAGES'({mosi_sync, spi_mosi});
            sck_d     <= sck_s;
            cs_d      <= cs_s;
        end
    end

    // Edge strobes and word images for the header and the next data word
    always_comb begin
        sck_s     = sck_sync[SYNC_STAGES-1];
        cs_s      = cs_sync[SYNC_STAGES-1];
        mosi_s    = mosi_sync[SYNC_STAGES-1];
        sck_rise  = sck_s && !sck_d;
        sck_fall  = !sck_s && sck_d;
        cs_rise   = cs_s && !cs_d;
        cs_fall   = !cs_s && cs_d;
        level_sat = (32'(fifo_level) > 32'd127) ? 7'd127 : 7'(fifo_level);
        hdr_word  = {overflow, level_sat, {(WORD_W-8){1'b0}}};
        sample_word = fifo_empty ? DATA_W'(EMPTY_WORD) : fifo_dout;
`ifdef ESP_SPI_CRC_EN
        data_word = WORD_W'({sample_word, crc8(24'(sample_word))});
`else
        data_word = WORD_W'(sample_word);
`endif
        last_idx  = (state == HDR) ? CNT_W'(HDR_BITS - 1) : CNT_W'(WORD_W - 1);
    end

    // Next-state and datapath decode
    always_comb begin
        state_nxt     = state;
        tx_sr_nxt     = tx_sr;
        bit_cnt_nxt   = bit_cnt;
        word_done_nxt = word_done;
        cmd_nxt       = cmd;
        miso_nxt      = spi_miso;
        oe_nxt        = spi_miso_oe;
        ovf_nxt       = overflow;
        pop_c         = 1'b0;
        case (state)
            WAIT_CS_HIGH: begin
                if (cs_s) state_nxt = IDLE;
            end
            IDLE: begin
                if (cs_fall) begin
                    state_nxt     = HDR;
                    tx_sr_nxt     = hdr_word << 1;
                    miso_nxt      = hdr_word[WORD_W-1];
                    oe_nxt        = 1'b1;
                    bit_cnt_nxt   = '0;
                    word_done_nxt = 1'b0;
                    ovf_nxt       = 1'b0;
                end
            end
            HDR, DATA: begin
                if (sck_rise) begin
                    if (state == HDR) cmd_nxt = {cmd[6:0], mosi_s};
                    if (bit_cnt == last_idx) begin
                        bit_cnt_nxt   = '0;
                        word_done_nxt = 1'b1;
                    end else begin
                        bit_cnt_nxt   = bit_cnt + CNT_W'(1);
                    end
                end else if (sck_fall) begin
                    if (!word_done) begin
                        miso_nxt  = tx_sr[WORD_W-1];
                        tx_sr_nxt = tx_sr << 1;
                    end else if (state == HDR && cmd != CMD_READ) begin
                        state_nxt = DRAIN;
                        miso_nxt  = 1'b0;
                        oe_nxt    = 1'b0;
                    end else begin
                        state_nxt     = DATA;
                        pop_c         = !fifo_empty;
                        tx_sr_nxt     = data_word << 1;
                        miso_nxt      = data_word[WORD_W-1];
                        word_done_nxt = 1'b0;
                        bit_cnt_nxt   = '0;
                    end
                end
            end
            DRAIN: begin
                miso_nxt = 1'b0;
                oe_nxt   = 1'b0;
            end
            default: state_nxt = WAIT_CS_HIGH;
        endcase
        // CS deassertion aborts any transaction; a partial word is simply lost
        if (cs_rise && state != WAIT_CS_HIGH) begin
            state_nxt = IDLE;
            miso_nxt  = 1'b0;
            oe_nxt    = 1'b0;
            pop_c     = 1'b0;
        end
        // A dropped sample sets the flag even in the cycle the header clears it
        if (sample_valid && fifo_full && !pop_c) ovf_nxt = 1'b1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= WAIT_CS_HIGH;
        else       state <= state_nxt;
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_sr       <= '0;
            bit_cnt     <= '0;
            word_done   <= 1'b0;
            cmd         <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            tx_sr       <= tx_sr_nxt;
            bit_cnt     <= bit_cnt_nxt;
            word_done   <= word_done_nxt;
            cmd         <= cmd_nxt;
            spi_miso    <= miso_nxt;
            spi_miso_oe <= oe_nxt;
            overflow    <= ovf_nxt;
            busy        <= (state_nxt == HDR) || (state_nxt == DATA) || (state_nxt == DRAIN);
        end
    end

endmodule

// File: tb/tb_esp_spi_target.sv
// tb_esp_spi_target: scoreboard bench; the bench acts as the SPI master (ESP32).
`timescale 1ns/1ps
module tb_esp_spi_target;

    localparam int unsigned FIFO_DEPTH  = 64;
    localparam int unsigned DATA_W      = 24;
    localparam int unsigned SYNC_STAGES = 2;
`ifdef ESP_SPI_CRC_EN
    localparam int WB = 32;
`else
    localparam int WB = 24;
`endif

    logic                           clk = 1'b0;
    logic                           reset;
    logic [DATA_W-1:0]              sample_in;
    logic                           sample_valid;
    logic                           spi_sck, spi_cs, spi_mosi;
    logic                           spi_miso, spi_miso_oe;
    logic [$clog2(FIFO_DEPTH):0]    fifo_level;
    logic                           overflow, busy;

    esp_spi_target #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .spi_sck      (spi_sck),
        .spi_cs       (spi_cs),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_miso_oe  (spi_miso_oe),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          oe_high = 0;
    logic [23:0] model_q[$];
    logic        model_ovf = 1'b0;
    logic [31:0] exp_q[$];
    logic        rx_bits[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte-wise CRC-8 (poly 0x07, init 0x00) over the three sample bytes
    function automatic logic [7:0] ref_crc(input logic [23:0] s);
        logic [7:0] c;
        logic [7:0] b;
        c = 8'h00;
        for (int k = 2; k >= 0; k--) begin
            b = s[k*8 +: 8];
            c = c ^ b;
            for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] s);
`ifdef ESP_SPI_CRC_EN
        return {s, ref_crc(s)};
`else
        return {8'h00, s};
`endif
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_sample(input logic [23:0] s);
        sample_in    = s;
        sample_valid = 1'b1;
        wait_clk(1);
        sample_valid = 1'b0;
        wait_clk(1);
        if (model_q.size() < FIFO_DEPTH) model_q.push_back(s);
        else                             model_ovf = 1'b1;
    endtask

    task automatic expect_header();
        logic [6:0] lvl;
        lvl = (model_q.size() > 127) ? 7'd127 : 7'(model_q.size());
        exp_q.push_back({24'h0, model_ovf, lvl});
        model_ovf = 1'b0;
    endtask

    task automatic expect_word();
        if (model_q.size() > 0) exp_q.push_back(exp_word(model_q.pop_front()));
        else                    exp_q.push_back(exp_word(24'h800000));
    endtask

    // One SPI bit: MOSI set in low phase, MISO captured just before the rising edge
    task automatic spi_bit(input logic b);
        spi_sck  = 1'b0;
        spi_mosi = b;
        wait_clk(4);
        rx_bits.push_back(spi_miso);
        if (spi_miso_oe) oe_high++;
        spi_sck = 1'b1;
        wait_clk(4);
    endtask

    task automatic send(input logic [7:0] cmd, input int nbits);
        rx_bits.delete();
        oe_high = 0;
        spi_cs  = 1'b0;
        for (int i = 0; i < nbits; i++) spi_bit((i < 8) ? cmd[7-i] : 1'b0);
    endtask

    // CS rises while SCK is still high so no trailing falling edge loads another word
    task automatic cs_high();
        spi_cs = 1'b1;
        wait_clk(4);
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        wait_clk(8);
    endtask

    task automatic check_next(input string tag, input int nbits);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < nbits; i++) v = {v[30:0], rx_bits.pop_front()};
        check(tag, v, exp_q.pop_front());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] s;
        reset = 1'b1; sample_in = '0; sample_valid = 1'b0;
        spi_sck = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
        wait_clk(5);
        check("rst_miso",  32'(spi_miso), 32'd0);
        check("rst_oe",    32'(spi_miso_oe), 32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        reset = 1'b0;
        wait_clk(6);

        // Three samples read back in order
        push_sample(24'h123456); push_sample(24'hABCDEF); push_sample(24'h000001);
        wait_clk(2);
        check("t1_level", 32'(fifo_level), 32'd3);
        expect_header(); repeat (3) expect_word();
        send(8'hA5, 8 + 3*WB);
        check("t1_busy", 32'(busy), 32'd1);
        cs_high();
        check_next("t1_hdr", 8);
        for (int i = 0; i < 3; i++) check_next($sformatf("t1_word%0d", i), WB);
        check("t1_level_end", 32'(fifo_level), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);

        // Empty FIFO returns EMPTY_WORD without side effects
        expect_header(); repeat (2) expect_word();
        send(8'hA5, 8 + 2*WB); cs_high();
        check_next("t2_hdr", 8);
        check_next("t2_word0", WB);
        check_next("t2_word1", WB);
        check("t2_level", 32'(fifo_level), 32'd0);
        check("t2_ovf", 32'(overflow), 32'd0);

        // Overflow, header flag, non-read command drains
        for (int i = 0; i < 66; i++) push_sample(24'h100000 + 24'(i));
        wait_clk(2);
        check("t3_ovf", 32'(overflow), 32'd1);
        check("t3_level", 32'(fifo_level), 32'd64);
        expect_header();
        send(8'h3C, 8 + 16);
        check("t3_ovf_clr", 32'(overflow), 32'd0);
        cs_high();
        check_next("t3_hdr", 8);
        check("t3_oe_cnt", 32'(oe_high), 32'd8);
        check("t3_level_kept", 32'(fifo_level), 32'd64);

        // Abort after 10 bits of the first word: that sample is lost
        expect_header();
        s = model_q.pop_front();
        exp_q.push_back(exp_word(s) >> (WB - 10));
        send(8'hA5, 8 + 10); cs_high();
        check_next("t5_hdr", 8);
        check_next("t5_partial", 10);
        expect_header(); expect_word();
        send(8'hA5, 8 + WB); cs_high();
        check_next("t5_hdr2", 8);
        check_next("t5_word", WB);
        check("t5_level", 32'(fifo_level), 32'd62);

        // Reset mid-word: output silent until CS seen high
        send(8'hA5, 8 + 5);
        reset = 1'b1;
        wait_clk(1);
        check("t6_oe_rst", 32'(spi_miso_oe), 32'd0);
        reset = 1'b0;
        model_q.delete(); model_ovf = 1'b0;
        oe_high = 0;
        for (int i = 0; i < 8; i++) spi_bit(1'b0);
        check("t6_oe_silent", 32'(oe_high), 32'd0);
        check("t6_level", 32'(fifo_level), 32'd0);
        cs_high();
        expect_header(); expect_word();
        send(8'hA5, 8 + WB); cs_high();
        check_next("t6_hdr", 8);
        check_next("t6_word", WB);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
